chunked_adder_n: RTL
====================

// Module: chunked_adder_n
// PURPOSE
// Parametrised multi-cycle add/subtract unit; generalises the 4-bit ripple full adder to WIDTH bits.
// Adds CHUNK bits per clock, LSB chunk first, with the carry held in a register between chunks.
// Uses valid/ready handshakes on input and output, so it drops into streaming datapaths on the FPGA board.
// Adds a subtract mode and a signed-overflow flag.
// PARAMETERS
// WIDTH  8  operand/result width in bits; must be an integer multiple of CHUNK
// CHUNK  4  bits added per clock; NCHUNK = WIDTH/CHUNK (>=1)
// PORTS
// clk        in   1      single clock, rising edge
// reset_n    in   1      synchronous reset, active-low
// in_valid   in   1      operands a/b/c_in/sub valid
// in_ready   out  1      unit can accept operands
// a          in   WIDTH  operand A (unsigned or two's complement)
// b          in   WIDTH  operand B
// c_in       in   1      carry in (add mode only)
// sub        in   1      0: a+b+c_in ; 1: a-b (c_in ignored)
// out_valid  out  1      result valid
// out_ready  in   1      consumer takes result
// sum        out  WIDTH  result bits
// carry      out  1      carry out of MSB (sub mode: 1 = no borrow)
// overflow   out  1      signed two's-complement overflow
// BEHAVIOUR
// - Reset: while reset_n=0 at a clk edge: state<=IDLE, chunk counter<=0, sum<=0, carry<=0, overflow<=0, out_valid<=0.
//   in_ready=0 while reset_n=0; in_ready=1 from the first cycle after release.
// - FSM states: IDLE, CALC, DONE. in_ready = (state==IDLE) && reset_n. out_valid = (state==DONE).
// - IDLE: in_valid&&in_ready at edge T: latch a, b_eff = sub ? ~b : b, cin0 = sub ? 1 : c_in.
//   Then counter<=0 and state->CALC.
// - CALC: each cycle adds chunk k: {c, s[k]} = a[k] + b_eff[k] + c_reg; c_reg<=c; k++.
//   After chunk NCHUNK-1, state->DONE.
// - Latency: accept at edge T -> out_valid=1 after edge T+NCHUNK (NCHUNK CALC cycles). WIDTH=8, CHUNK=4 -> 2.
// - NCHUNK=1 still makes one CALC cycle.
// - Outputs: sum, carry, overflow load only on the CALC->DONE edge.
//   They hold until the next result loads; not reset on handshake.
// - carry = carry out of the final chunk.
// - overflow = (a[W-1]==b_eff[W-1]) && (sum[W-1]!=a[W-1]).
// - DONE: holds out_valid and outputs stable until out_ready=1 at an edge, then state->IDLE.
//   No new accept in that same cycle, so max throughput is 1 op per NCHUNK+2 cycles.
// - Input handshake is ignored outside IDLE; operand changes during CALC/DONE do not affect the result.
// - Wrap-around: results are modulo 2^WIDTH; the excess appears only on carry.
// - reset_n=0 during CALC or DONE aborts the operation: IDLE, out_valid=0, outputs cleared, no result emitted.
// - Counter width is $clog2(NCHUNK) with a minimum of 1; there is no terminal-count overrun.
// TESTING (WIDTH=8, CHUNK=4; check every result with a scoreboard against a+b+c_in / a-b)
// 1 reset_n=0 for 3 cycles, then release -> all outputs 0; in_ready=1 on the first cycle after release.
// 2 add a=3,b=4,c_in=0 -> out_valid 2 edges after accept; sum=7, carry=0, overflow=0.
//   Then 9+9 -> sum=18, carry=0.
// 3 add a=200,b=100,c_in=1 -> sum=45 (301 mod 256), carry=1.
//   Then a=127,b=1,c_in=0 -> sum=128, overflow=1, carry=0.
// 4 sub a=5,b=9 -> sum=252 (0xFC), carry=0, overflow=0.
//   Then sub a=0x80,b=1 -> sum=0x7F, carry=1, overflow=1.
// 5 hold out_ready=0 for 5 cycles with in_valid=1 and new operands applied.
//   -> out_valid stays 1, sum stable, in_ready=0.
//   Then out_ready=1 -> IDLE next cycle; the new operands are accepted afterwards.
// 6 assert reset_n=0 in the first CALC cycle -> no out_valid pulse, outputs 0.
//   Next op 7+8 -> sum=15 with correct latency.
//   Also repeat tests 2-4 with CHUNK=8 (NCHUNK=1) and WIDTH=16, CHUNK=4.

Source files
------------

// File: rtl/chunked_adder_n.sv
// Multi-cycle WIDTH-bit add/subtract unit: CHUNK bits per clock, LSB chunk first,
// carry held between chunks, valid/ready handshakes on both sides.
module chunked_adder_n #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0]    IDLE = 2'd0;
    localparam logic [1:0]    CALC = 2'd1;
    localparam logic [1:0]    DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    logic [1:0]                   state_reg;
    logic [CW-1:0]                cnt_reg;
    logic [NCHUNK-1:0][CHUNK-1:0] a_reg;
    logic [NCHUNK-1:0][CHUNK-1:0] b_reg;
    logic [NCHUNK-1:0][CHUNK-1:0] acc_reg;
    logic                         c_reg;
    logic [WIDTH-1:0]             sum_reg;
    logic                         carry_reg;
    logic                         overflow_reg;

    logic [CHUNK-1:0]             chunk_sum;
    logic                         chunk_carry;
    logic [NCHUNK-1:0][CHUNK-1:0] sum_next;
    logic                         overflow_next;

    assign {chunk_carry, chunk_sum} = {1'b0, a_reg[cnt_reg]} + {1'b0, b_reg[cnt_reg]}
                                    + {{CHUNK{1'b0}}, c_reg};

    // Merge the chunk being computed this cycle into the partial result.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_merge
            assign sum_next[gi] = (cnt_reg == CW'(gi)) ? chunk_sum : acc_reg[gi];
        end
    endgenerate

    // b_reg already holds the inverted operand in subtract mode.
    assign overflow_next = (a_reg[NCHUNK-1][CHUNK-1] == b_reg[NCHUNK-1][CHUNK-1])
                        && (sum_next[NCHUNK-1][CHUNK-1] != a_reg[NCHUNK-1][CHUNK-1]);

    assign in_ready  = (state_reg == IDLE) && reset_n;
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign carry     = carry_reg;
    assign overflow  = overflow_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            acc_reg      <= '0;
            c_reg        <= 1'b0;
            sum_reg      <= '0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        c_reg     <= sub | c_in;
                        cnt_reg   <= '0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    acc_reg <= sum_next;
                    c_reg   <= chunk_carry;
                    if (cnt_reg == LAST) begin
                        state_reg    <= DONE;
                        sum_reg      <= sum_next;
                        carry_reg    <= chunk_carry;
                        overflow_reg <= overflow_next;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
